// File: rtl/acc40_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : acc40_pkg
//  Purpose  : Shared definitions for the 40-bit sequential accumulator.
//             DATA_W      - datapath width of the accumulator and adder.
//             acc_state_t - run-control FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package acc40_pkg;

  localparam int DATA_W = 40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

endpackage : acc40_pkg
`default_nettype wire

// File: rtl/rca_40b.sv
`default_nettype none
// ============================================================================
//  Module   : rca_40b
//  Purpose  : 40-bit ripple-carry adder, one full adder per bit.
//  Ports    : a_i    [39:0] in  - addend A
//             b_i    [39:0] in  - addend B
//             cin_i         in  - carry in
//             sum_o  [39:0] out - A + B + Cin, modulo 2^40
//             cout_o        out - carry out of bit 39
//  Revision : 1.0 - initial release
// ============================================================================
module rca_40b
  import acc40_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              cin_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              cout_o
);

  logic [DATA_W:0] w_carry;

  assign w_carry[0] = cin_i;

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    assign sum_o[i]       = a_i[i] ^ b_i[i] ^ w_carry[i];
    assign w_carry[i + 1] = (a_i[i] & b_i[i]) | (w_carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = w_carry[DATA_W];

endmodule : rca_40b
`default_nettype wire

// File: rtl/acc40_seq.sv
`default_nettype none
// ============================================================================
//  Module   : acc40_seq
//  Purpose  : Accumulates a run of len_i 40-bit operands (add or subtract)
//             through rca_40b, counts adder carry-outs and presents a single
//             result beat when the run completes.
//  Ports    : clk, rst_n              - clock, async active-low reset
//             start_i, len_i, sub_i   - run request, length, subtract mode
//             in_valid_i/in_ready_o   - operand stream handshake
//             in_data_i [39:0]        - operand
//             out_valid_o/out_ready_i - result handshake
//             out_sum_o [39:0]        - accumulated value
//             out_carries_o           - count of beats with Cout = 1
//             busy_o                  - high outside IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module acc40_seq
  import acc40_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic              sub_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_sum_o,
  output logic [CNT_W-1:0]  out_carries_o,
  output logic              busy_o
);

  acc_state_t        state_q;
  logic [DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]  carries_q;
  logic [CNT_W-1:0]  remaining_q;
  logic              mode_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;

  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] acc_d;
  logic              w_cout;
  logic [CNT_W-1:0]  carries_d;
  logic [CNT_W-1:0]  remaining_d;
  logic              w_accept;
  logic              w_last;

  // Subtraction is A + ~B + 1; Cout = 1 then means "no borrow".
  assign w_b = mode_q ? ~in_data_i : in_data_i;

  rca_40b u_rca (
    .a_i    (acc_q),
    .b_i    (w_b),
    .cin_i  (mode_q),
    .sum_o  (acc_d),
    .cout_o (w_cout)
  );

  assign carries_d   = carries_q + {{(CNT_W-1){1'b0}}, w_cout};
  assign remaining_d = remaining_q - {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_accept    = in_valid_i && in_ready_q;
  assign w_last      = (remaining_q == {{(CNT_W-1){1'b0}}, 1'b1});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      carries_q   <= '0;
      remaining_q <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            acc_q       <= '0;
            carries_q   <= '0;
            remaining_q <= len_i;
            mode_q      <= sub_i;
            busy_q      <= 1'b1;
            if (len_i != '0) begin
              state_q    <= ACCUM;
              in_ready_q <= 1'b1;
            end else begin
              // Empty run: result is the freshly cleared registers.
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (w_accept) begin
            acc_q       <= acc_d;
            carries_q   <= carries_d;
            remaining_q <= remaining_d;
            if (w_last) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = out_valid_q;
  assign busy_o        = busy_q;
  assign out_sum_o     = acc_q;
  assign out_carries_o = carries_q;

endmodule : acc40_seq
`default_nettype wire
